// File: rtl/spi_cmd_decoder_pkg.sv
// Shared types and constants for the SPI command decoder.
// Opcode fields, action codes, FSM states and the CRC-8 helper.
package spi_cmd_decoder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WR_DATA,
        RD_DATA,
        WR_CRC
    } state_t;

    localparam logic [1:0] OP_ACTION = 2'b00;
    localparam logic [1:0] OP_READ   = 2'b01;
    localparam logic [1:0] OP_WRITE  = 2'b10;
    localparam logic [1:0] OP_RSVD   = 2'b11;

    localparam logic [5:0] CMD_START = 6'h06;
    localparam logic [7:0] CRC_POLY  = 8'h07;

    function automatic logic [7:0] crc8(input logic [7:0] c,
                                        input logic [7:0] d);
        logic [7:0] r;
        r = c ^ d;
        for (int i = 0; i < 8; i++) begin
            r = r[7] ? ((r << 1) ^ CRC_POLY) : (r << 1);
        end
        return r;
    endfunction

endpackage

// File: rtl/spi_cmd_decoder_if.sv
// SPI slave bus bundle (mode 0).
// The master drives sclk/mosi/cs_n, the slave drives miso.
interface spi_cmd_decoder_if;
    logic sclk;
    logic mosi;
    logic cs_n;
    logic miso;

    modport master (output sclk, output mosi, output cs_n, input miso);
    modport slave  (input sclk, input mosi, input cs_n, output miso);
endinterface

// File: rtl/spi_cmd_decoder_phy.sv
// SPI mode-0 byte PHY: synchronisers, edge detect, rx/tx shifters.
// Emits byte_valid on a clean 8-bit frame, err_frame otherwise.
module spi_cmd_decoder_phy #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_in,
    input  logic       sys_rst,
    input  logic       sclk,
    input  logic       mosi,
    input  logic       cs_n,
    input  logic [7:0] tx_data,
    output logic       miso,
    output logic [7:0] rx_data,
    output logic       byte_valid,
    output logic       err_frame
);

    logic [SYNC_STAGES-1:0] sclk_sr, mosi_sr, cs_sr;
    logic sclk_q, cs_q;
    logic sclk_s, mosi_s, cs_s;
    logic rise, fall, cs_rise, cs_fall;
    logic [3:0] cnt;
    logic [7:0] rx_sr, tx_sr;

    assign sclk_s  = sclk_sr[SYNC_STAGES-1];
    assign mosi_s  = mosi_sr[SYNC_STAGES-1];
    assign cs_s    = cs_sr[SYNC_STAGES-1];
    assign rise    = sclk_s & ~sclk_q;
    assign fall    = ~sclk_s & sclk_q;
    assign cs_rise = cs_s & ~cs_q;
    assign cs_fall = ~cs_s & cs_q;
    assign miso    = tx_sr[7];
    assign rx_data = rx_sr;

    // Equal-depth synchronisers keep mosi aligned with sclk edges.
    always_ff @(posedge clk_in or posedge sys_rst) begin
        if (sys_rst) begin
            sclk_sr <= '0;
            mosi_sr <= '0;
            cs_sr   <= '1;
            sclk_q  <= 1'b0;
            cs_q    <= 1'b1;
        end else begin
            sclk_sr <= {sclk_sr[SYNC_STAGES-2:0], sclk};
            mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], mosi};
            cs_sr   <= {cs_sr[SYNC_STAGES-2:0], cs_n};
            sclk_q  <= sclk_s;
            cs_q    <= cs_s;
        end
    end

    // Shift on edges; count bits and judge the frame on cs_n rise.
    always_ff @(posedge clk_in or posedge sys_rst) begin
        if (sys_rst) begin
            cnt        <= '0;
            rx_sr      <= '0;
            tx_sr      <= '0;
            byte_valid <= 1'b0;
            err_frame  <= 1'b0;
        end else begin
            byte_valid <= cs_rise && (cnt == 4'd8);
            err_frame  <= cs_rise && (cnt != 4'd8);
            if (cs_fall) begin
                tx_sr <= tx_data;
            end else if (fall && !cs_s) begin
                tx_sr <= {tx_sr[6:0], 1'b0};
            end
            if (cs_s) begin
                cnt <= '0;
            end else if (rise) begin
                rx_sr <= {rx_sr[6:0], mosi_s};
                if (cnt != 4'hF) cnt <= cnt + 4'd1;
            end
        end
    end

endmodule

// File: rtl/spi_cmd_decoder.sv
// SPI command decoder: opcode FSM, payload assembly, timeout.
// Build macro SPI_CRC8_EN adds a trailing CRC-8 byte to WRITE/READ.
module spi_cmd_decoder
    import spi_cmd_decoder_pkg::*;
#(
    parameter int DATA_BYTES  = 2,
    parameter int NUM_REGS    = 32,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic                    clk_in,
    input  logic                    sys_rst,
    spi_cmd_decoder_if.slave        spi,
    output logic                    reg_wr_en,
    output logic [5:0]              reg_wr_addr,
    output logic [8*DATA_BYTES-1:0] reg_wr_data,
    output logic [5:0]              reg_rd_addr,
    input  logic [8*DATA_BYTES-1:0] reg_rd_data,
    output logic                    cmd_valid,
    output logic [5:0]              cmd_code,
    output logic                    err_frame,
    output logic                    err_timeout,
    output logic                    err_addr,
    output logic                    busy
);

`ifdef SPI_CRC8_EN
    localparam bit CRC_EN = 1'b1;
`else
    localparam bit CRC_EN = 1'b0;
`endif
    localparam int W  = 8 * DATA_BYTES;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [2:0] LAST_WR = 3'(DATA_BYTES - 1);
    localparam logic [2:0] LAST_RD = 3'(DATA_BYTES - 1 + int'(CRC_EN));

    state_t state, state_d;
    logic bv, fe, phy_miso;
    logic [7:0] rx, tx;
    logic [2:0] idx;
    logic bad, addr_bad, timeout, commit, crc_bad;
    logic [W-1:0] wr_word, rd_word, word_next;
    logic [W+7:0] rd_ext;
    logic [TW-1:0] timer;
    logic [1:0] rd_pend;
    logic [7:0] crc;

    spi_cmd_decoder_phy #(.SYNC_STAGES(SYNC_STAGES)) u_phy (
        .clk_in     (clk_in),
        .sys_rst    (sys_rst),
        .sclk       (spi.sclk),
        .mosi       (spi.mosi),
        .cs_n       (spi.cs_n),
        .tx_data    (tx),
        .miso       (phy_miso),
        .rx_data    (rx),
        .byte_valid (bv),
        .err_frame  (fe)
    );

    assign busy     = (state != IDLE);
    assign spi.miso = phy_miso & (state == RD_DATA);
    assign rd_ext   = {crc, rd_word};
    assign tx       = (state == RD_DATA) ? rd_ext[int'(idx)*8 +: 8] : 8'h00;

    // Next-state decode, commit decision and timeout detection.
    always_comb begin
        state_d   = state;
        commit    = 1'b0;
        crc_bad   = 1'b0;
        addr_bad  = int'(rx[5:0]) >= NUM_REGS;
        timeout   = (state != IDLE) && !bv &&
                    (timer == TW'(TIMEOUT_CYC - 1));
        word_next = wr_word;
        word_next[int'(idx)*8 +: 8] = rx;
        if (timeout) begin
            state_d = IDLE;
        end else if (bv) begin
            case (state)
                IDLE: begin
                    if (rx[7:6] == OP_WRITE) state_d = WR_DATA;
                    if (rx[7:6] == OP_READ)  state_d = RD_DATA;
                end
                WR_DATA: begin
                    if (idx == LAST_WR) begin
                        if (CRC_EN) begin
                            state_d = WR_CRC;
                        end else begin
                            state_d = IDLE;
                            commit  = !bad;
                        end
                    end
                end
                WR_CRC: begin
                    state_d = IDLE;
                    commit  = !bad && (rx == crc);
                    crc_bad = (rx != crc);
                end
                RD_DATA: begin
                    if (idx == LAST_RD) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk_in or posedge sys_rst) begin
        if (sys_rst) state <= IDLE;
        else         state <= state_d;
    end

    // Datapath: strobes, payload, read latch, CRC and timer.
    always_ff @(posedge clk_in or posedge sys_rst) begin
        if (sys_rst) begin
            reg_wr_en   <= 1'b0;
            reg_wr_addr <= '0;
            reg_wr_data <= '0;
            reg_rd_addr <= '0;
            cmd_valid   <= 1'b0;
            cmd_code    <= '0;
            err_frame   <= 1'b0;
            err_timeout <= 1'b0;
            err_addr    <= 1'b0;
            idx         <= '0;
            bad         <= 1'b0;
            wr_word     <= '0;
            rd_word     <= '0;
            timer       <= '0;
            rd_pend     <= '0;
            crc         <= '0;
        end else begin
            reg_wr_en   <= 1'b0;
            cmd_valid   <= 1'b0;
            err_addr    <= 1'b0;
            err_frame   <= fe | crc_bad;
            err_timeout <= timeout;
            rd_pend     <= {rd_pend[0], 1'b0};
            if (rd_pend[1]) rd_word <= bad ? '0 : reg_rd_data;
            if (state_d == IDLE || bv) timer <= '0;
            else                       timer <= timer + 1'b1;
            if (commit) begin
                reg_wr_en   <= 1'b1;
                reg_wr_data <= CRC_EN ? wr_word : word_next;
            end
            if (bv) begin
                case (state)
                    IDLE: begin
                        idx <= '0;
                        crc <= crc8(8'h00, rx);
                        case (rx[7:6])
                            OP_WRITE: begin
                                reg_wr_addr <= rx[5:0];
                                bad         <= addr_bad;
                                err_addr    <= addr_bad;
                                wr_word     <= '0;
                            end
                            OP_READ: begin
                                reg_rd_addr <= rx[5:0];
                                bad         <= addr_bad;
                                err_addr    <= addr_bad;
                                rd_pend     <= 2'b01;
                                crc         <= 8'h00;
                            end
                            OP_ACTION: begin
                                cmd_valid <= 1'b1;
                                cmd_code  <= rx[5:0];
                            end
                            default: ;
                        endcase
                    end
                    WR_DATA: begin
                        wr_word <= word_next;
                        idx     <= idx + 3'd1;
                        crc     <= crc8(crc, rx);
                    end
                    RD_DATA: begin
                        idx <= idx + 3'd1;
                        crc <= crc8(crc, tx);
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Scoreboard bench for spi_cmd_decoder: directed SPI transactions.
// Expected events are queued at issue; a monitor pops on DUT output.
`timescale 1ns/1ps
module tb_spi_cmd_decoder;

    localparam int K_WR  = 0;
    localparam int K_CMD = 1;
    localparam int K_EFR = 2;
    localparam int K_ETO = 3;
    localparam int K_EAD = 4;
    localparam int K_RD  = 5;

    typedef struct {
        int          kind;
        logic [31:0] val;
    } ev_t;

    logic clk_in = 1'b0;
    logic sys_rst = 1'b1;
    logic reg_wr_en, cmd_valid, err_frame, err_timeout, err_addr, busy;
    logic [5:0] reg_wr_addr, reg_rd_addr, cmd_code;
    logic [15:0] reg_wr_data, reg_rd_data;
    logic [15:0] rf [64];
    logic [7:0] rx_last, dummy;

    ev_t exp_q[$];
    int checks = 0;
    int failures = 0;
    int rx_cnt = 0;
    int rx_seen = 0;

    always #10 clk_in = ~clk_in;

    spi_cmd_decoder_if spi_bus ();

    assign reg_rd_data = rf[reg_rd_addr];

    spi_cmd_decoder dut (
        .clk_in      (clk_in),
        .sys_rst     (sys_rst),
        .spi         (spi_bus),
        .reg_wr_en   (reg_wr_en),
        .reg_wr_addr (reg_wr_addr),
        .reg_wr_data (reg_wr_data),
        .reg_rd_addr (reg_rd_addr),
        .reg_rd_data (reg_rd_data),
        .cmd_valid   (cmd_valid),
        .cmd_code    (cmd_code),
        .err_frame   (err_frame),
        .err_timeout (err_timeout),
        .err_addr    (err_addr),
        .busy        (busy)
    );

    function automatic logic [7:0] crc8(input logic [7:0] c,
                                        input logic [7:0] d);
        logic [7:0] r;
        r = c ^ d;
        for (int i = 0; i < 8; i++)
            r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
        return r;
    endfunction

    task automatic push(input int kind, input logic [31:0] val);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic got(input int kind, input logic [31:0] val);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event kind=%0d val=%h required none",
                     kind, val);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.val != val) begin
                failures++;
                $display("FAIL event got kind=%0d val=%h required kind=%0d val=%h",
                         kind, val, e.kind, e.val);
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: every DUT output event is checked against the queue.
    always @(negedge clk_in) begin
        if (!sys_rst) begin
            if (err_addr)    got(K_EAD, 32'd0);
            if (err_frame)   got(K_EFR, 32'd0);
            if (err_timeout) got(K_ETO, 32'd0);
            if (cmd_valid)   got(K_CMD, {26'd0, cmd_code});
            if (reg_wr_en)   got(K_WR, {10'd0, reg_wr_addr, reg_wr_data});
            if (rx_cnt != rx_seen) begin
                rx_seen = rx_cnt;
                got(K_RD, {24'd0, rx_last});
            end
        end
    end

    task automatic spi_frame(input logic [7:0] tx, input int nbits,
                             input int half, output logic [7:0] rx);
        rx = 8'h00;
        spi_bus.cs_n = 1'b0;
        #100;
        for (int i = 0; i < nbits; i++) begin
            spi_bus.mosi = tx[7-i];
            #half;
            rx = {rx[6:0], spi_bus.miso};
            spi_bus.sclk = 1'b1;
            #half;
            spi_bus.sclk = 1'b0;
        end
        #100;
        spi_bus.cs_n = 1'b1;
        spi_bus.mosi = 1'b0;
        #200;
    endtask

    task automatic send(input logic [7:0] b);
        logic [7:0] r;
        spi_frame(b, 8, 30, r);
    endtask

    task automatic read_byte();
        logic [7:0] r;
        spi_frame(8'h00, 8, 200, r);
        rx_last = r;
        rx_cnt++;
    endtask

    task automatic write_reg(input logic [7:0] op, input logic [15:0] d);
        send(op);
        send(d[7:0]);
        send(d[15:8]);
`ifdef SPI_CRC8_EN
        send(crc8(crc8(crc8(8'h00, op), d[7:0]), d[15:8]));
`endif
    endtask

    initial begin
        spi_bus.cs_n = 1'b1;
        spi_bus.sclk = 1'b0;
        spi_bus.mosi = 1'b0;
        for (int i = 0; i < 64; i++) rf[i] = 16'hA500 + 16'(i);
        rf[28] = 16'h0004;
        rf[63] = 16'hBEEF;
        repeat (5) @(negedge clk_in);
        sys_rst = 1'b0;
        @(negedge clk_in);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_miso", {31'd0, spi_bus.miso}, 32'd0);
        chk("rst_wr_en", {31'd0, reg_wr_en}, 32'd0);
        chk("rst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
        chk("rst_err_frame", {31'd0, err_frame}, 32'd0);

        // Basic write at the fastest supported sclk.
        push(K_WR, {10'd0, 6'h11, 16'h0064});
        send(8'h91);
        chk("wr_busy_open", {31'd0, busy}, 32'd1);
        send(8'h64);
        send(8'h00);
`ifdef SPI_CRC8_EN
        send(crc8(crc8(crc8(8'h00, 8'h91), 8'h64), 8'h00));
`endif
        chk("wr_busy_done", {31'd0, busy}, 32'd0);

        // Action strobe.
        push(K_CMD, 32'h06);
        send(8'h06);
        chk("act_busy", {31'd0, busy}, 32'd0);

        // Read-back of register 0x1C.
        push(K_RD, 32'h04);
        push(K_RD, 32'h00);
`ifdef SPI_CRC8_EN
        push(K_RD, {24'd0, crc8(crc8(8'h00, 8'h04), 8'h00)});
`endif
        send(8'h5C);
        chk("rd_addr", {26'd0, reg_rd_addr}, 32'h1C);
        read_byte();
        read_byte();
`ifdef SPI_CRC8_EN
        read_byte();
`endif
        chk("rd_busy_done", {31'd0, busy}, 32'd0);
        chk("rd_miso_idle", {31'd0, spi_bus.miso}, 32'd0);

        // Short frame inside a write; the write still completes.
        push(K_EFR, 32'd0);
        push(K_WR, {10'd0, 6'h05, 16'hCDAB});
        send(8'h85);
        spi_frame(8'hF0, 5, 30, dummy);
        send(8'hAB);
        send(8'hCD);
`ifdef SPI_CRC8_EN
        send(crc8(crc8(crc8(8'h00, 8'h85), 8'hAB), 8'hCD));
`endif

        // Abandoned write times out.
        send(8'h93);
        send(8'h3C);
        chk("to_busy_open", {31'd0, busy}, 32'd1);
        push(K_ETO, 32'd0);
        repeat (50100) @(negedge clk_in);
        chk("to_busy_done", {31'd0, busy}, 32'd0);

        // Reset mid-transaction discards it.
        send(8'h9E);
        send(8'h77);
        @(negedge clk_in);
        sys_rst = 1'b1;
        repeat (3) @(negedge clk_in);
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        sys_rst = 1'b0;
        @(negedge clk_in);
        push(K_WR, {10'd0, 6'h1E, 16'h0032});
        write_reg(8'h9E, 16'h0032);

        // Out-of-range write and read keep framing.
        push(K_EAD, 32'd0);
        write_reg(8'hA5, 16'h1234);
        push(K_EAD, 32'd0);
        push(K_RD, 32'h00);
        push(K_RD, 32'h00);
`ifdef SPI_CRC8_EN
        push(K_RD, 32'h00);
`endif
        send(8'h7F);
        read_byte();
        read_byte();
`ifdef SPI_CRC8_EN
        read_byte();
`endif
        chk("bad_busy_done", {31'd0, busy}, 32'd0);

        // Reserved opcode is ignored.
        send(8'hC3);
        chk("rsvd_busy", {31'd0, busy}, 32'd0);
        push(K_CMD, 32'h15);
        send(8'h15);

`ifdef SPI_CRC8_EN
        // Corrupted CRC rejects the write.
        push(K_EFR, 32'd0);
        send(8'h82);
        send(8'h11);
        send(8'h22);
        send(crc8(crc8(crc8(8'h00, 8'h82), 8'h11), 8'h22) ^ 8'hFF);
        chk("crc_bad_busy", {31'd0, busy}, 32'd0);
`endif

        repeat (20) @(negedge clk_in);
        chk("drain", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
